// File: rtl/cdb_arbiter_pkg.sv
// rtl/cdb_arbiter_pkg.sv - shared widths and CDB source encodings for the result bus
package cdb_arbiter_pkg;

  localparam int TAG_WIDTH  = 5;
  localparam int DATA_WIDTH = 32;
  localparam int NUM_REQ    = 3;

  typedef enum logic [1:0] {
    CDB_SRC_ALU    = 2'd0,
    CDB_SRC_BRANCH = 2'd1,
    CDB_SRC_LS     = 2'd2
  } cdb_src_e;

  // Round-robin successor over the three requesters.
  function automatic cdb_src_e rr_next(input cdb_src_e s);
    case (s)
      CDB_SRC_ALU:    return CDB_SRC_BRANCH;
      CDB_SRC_BRANCH: return CDB_SRC_LS;
      default:        return CDB_SRC_ALU;
    endcase
  endfunction

endpackage

// File: rtl/cdb_queue.sv
// rtl/cdb_queue.sv - per-requester result FIFO feeding the CDB arbiter
module cdb_queue
  import cdb_arbiter_pkg::*;
#(
  parameter int TAG_W  = TAG_WIDTH,
  parameter int DATA_W = DATA_WIDTH,
  parameter int QDEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  logic [TAG_W-1:0]         push_tag,
  input  logic [DATA_W-1:0]        push_data,
  input  logic                     pop,
  output logic [TAG_W-1:0]         head_tag,
  output logic [DATA_W-1:0]        head_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(QDEPTH):0]  count
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;

  logic [TAG_W-1:0]  mem_tag_q  [QDEPTH];
  logic [TAG_W-1:0]  mem_tag_d  [QDEPTH];
  logic [DATA_W-1:0] mem_data_q [QDEPTH];
  logic [DATA_W-1:0] mem_data_d [QDEPTH];
  logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              do_push, do_pop;

  assign full      = (count_q == CW'(QDEPTH));
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign head_tag  = mem_tag_q[rd_ptr_q];
  assign head_data = mem_data_q[rd_ptr_q];
  assign do_push   = push && !full;
  assign do_pop    = pop && !empty;

  always_comb begin
    mem_tag_d  = mem_tag_q;
    mem_data_d = mem_data_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_tag_d[wr_ptr_q]  = push_tag;
        mem_data_d[wr_ptr_q] = push_data;
        wr_ptr_d             = wr_ptr_q + PW'(1);
      end
      if (do_pop) rd_ptr_d = rd_ptr_q + PW'(1);
      count_d = count_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Payload storage needs no reset: occupancy alone decides what is valid.
  always_ff @(posedge clk) begin
    mem_tag_q  <= mem_tag_d;
    mem_data_q <= mem_data_d;
  end

endmodule

// File: rtl/cdb_arbiter.sv
// rtl/cdb_arbiter.sv - round-robin arbiter broadcasting ALU/branch/LS results on the CDB
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int TAG_W  = TAG_WIDTH,
  parameter int DATA_W = DATA_WIDTH,
  parameter int QDEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              alu_valid,
  input  logic [TAG_W-1:0]  alu_tag,
  input  logic [DATA_W-1:0] alu_data,
  output logic              alu_ready,
  input  logic              br_valid,
  input  logic [TAG_W-1:0]  br_tag,
  input  logic [DATA_W-1:0] br_data,
  output logic              br_ready,
  input  logic              ls_valid,
  input  logic [TAG_W-1:0]  ls_tag,
  input  logic [DATA_W-1:0] ls_data,
  output logic              ls_ready,
  output logic              cdb_valid,
  output logic [TAG_W-1:0]  cdb_tag,
  output logic [DATA_W-1:0] cdb_data,
  output logic [1:0]        cdb_src
);

  localparam int CW = $clog2(QDEPTH) + 1;
  // The free encoding is the tag MSB set with all other bits clear.
  localparam logic [TAG_W-1:0] TagFree = {1'b1, {(TAG_W-1){1'b0}}};

  logic [NUM_REQ-1:0] req_valid, req_ready, q_push, q_pop, q_full, q_empty;
  logic [TAG_W-1:0]   req_tag   [NUM_REQ];
  logic [DATA_W-1:0]  req_data  [NUM_REQ];
  logic [TAG_W-1:0]   head_tag  [NUM_REQ];
  logic [DATA_W-1:0]  head_data [NUM_REQ];
  logic [CW-1:0]      q_count   [NUM_REQ];

  logic               run_q;
  cdb_src_e           last_grant_q, last_grant_d;
  logic               cdb_valid_q, cdb_valid_d;
  logic [TAG_W-1:0]   cdb_tag_q, cdb_tag_d;
  logic [DATA_W-1:0]  cdb_data_q, cdb_data_d;
  cdb_src_e           cdb_src_q, cdb_src_d;
  logic               grant_v;
  cdb_src_e           grant_idx, cand;

  assign req_valid = {ls_valid, br_valid, alu_valid};
  assign req_tag   = '{alu_tag, br_tag, ls_tag};
  assign req_data  = '{alu_data, br_data, ls_data};
  assign alu_ready = req_ready[0];
  assign br_ready  = req_ready[1];
  assign ls_ready  = req_ready[2];

  for (genvar r = 0; r < NUM_REQ; r++) begin : g_q
    cdb_queue #(.TAG_W(TAG_W), .DATA_W(DATA_W), .QDEPTH(QDEPTH)) u_queue (
      .clk       (clk),
      .rst       (rst),
      .flush     (flush),
      .push      (q_push[r]),
      .push_tag  (req_tag[r]),
      .push_data (req_data[r]),
      .pop       (q_pop[r]),
      .head_tag  (head_tag[r]),
      .head_data (head_data[r]),
      .full      (q_full[r]),
      .empty     (q_empty[r]),
      .count     (q_count[r])
    );
    // Ready depends only on registered occupancy, so a full queue stays
    // not-ready even in a cycle where its head is being popped.
    assign req_ready[r] = run_q && (q_count[r] < CW'(QDEPTH));
    assign q_push[r]    = req_valid[r] && req_ready[r] && !q_full[r]
                          && (req_tag[r] != TagFree);
  end

  always_comb begin
    grant_v   = 1'b0;
    grant_idx = CDB_SRC_ALU;
    cand      = rr_next(last_grant_q);
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!grant_v && !q_empty[cand]) begin
        grant_v   = 1'b1;
        grant_idx = cand;
      end
      cand = rr_next(cand);
    end

    q_pop        = '0;
    last_grant_d = last_grant_q;
    cdb_valid_d  = 1'b0;
    cdb_tag_d    = TagFree;
    cdb_data_d   = '0;
    cdb_src_d    = CDB_SRC_ALU;
    if (grant_v && !flush) begin
      q_pop[grant_idx] = 1'b1;
      last_grant_d     = grant_idx;
      cdb_valid_d      = 1'b1;
      cdb_tag_d        = head_tag[grant_idx];
      cdb_data_d       = head_data[grant_idx];
      cdb_src_d        = grant_idx;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      run_q        <= 1'b0;
      last_grant_q <= CDB_SRC_LS;
      cdb_valid_q  <= 1'b0;
      cdb_tag_q    <= TagFree;
      cdb_data_q   <= '0;
      cdb_src_q    <= CDB_SRC_ALU;
    end else begin
      run_q        <= 1'b1;
      last_grant_q <= last_grant_d;
      cdb_valid_q  <= cdb_valid_d;
      cdb_tag_q    <= cdb_tag_d;
      cdb_data_q   <= cdb_data_d;
      cdb_src_q    <= cdb_src_d;
    end
  end

  assign cdb_valid = cdb_valid_q;
  assign cdb_tag   = cdb_tag_q;
  assign cdb_data  = cdb_data_q;
  assign cdb_src   = cdb_src_q;

endmodule

// File: tb/tb_cdb_arbiter.sv
// tb/tb_cdb_arbiter.sv - directed-vector bench for cdb_arbiter
module tb_cdb_arbiter;

  logic        clk, rst, flush;
  logic        alu_valid, br_valid, ls_valid;
  logic [4:0]  alu_tag, br_tag, ls_tag;
  logic [31:0] alu_data, br_data, ls_data;
  logic        alu_ready, br_ready, ls_ready;
  logic        cdb_valid;
  logic [4:0]  cdb_tag;
  logic [31:0] cdb_data;
  logic [1:0]  cdb_src;

  int n_vec = 0;
  int n_err = 0;

  localparam logic [4:0] TFREE = 5'd16;

  // Round-robin run: expected bus contents and {alu,br,ls} ready after each edge.
  localparam logic        RR_VALID [13] = '{0,1,1,1,1,1,1,1,1,1,1,1,0};
  localparam logic [1:0]  RR_SRC   [13] = '{0,0,1,2,0,1,2,0,1,2,0,1,0};
  localparam logic [4:0]  RR_TAG   [13] = '{16,1,2,3,1,2,3,1,2,3,1,2,16};
  localparam logic [31:0] RR_DATA  [13] = '{32'h0, 32'h0A01, 32'h0B01, 32'h0C01,
                                            32'h0A02, 32'h0B02, 32'h0C02, 32'h0A03,
                                            32'h0B03, 32'h0C03, 32'h0A04, 32'h0B04, 32'h0};
  localparam logic [2:0]  RR_RDY   [13] = '{3'b111, 3'b100, 3'b010, 3'b001, 3'b100,
                                            3'b010, 3'b001, 3'b101, 3'b111, 3'b111,
                                            3'b111, 3'b111, 3'b111};

  cdb_arbiter dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .alu_valid (alu_valid),
    .alu_tag   (alu_tag),
    .alu_data  (alu_data),
    .alu_ready (alu_ready),
    .br_valid  (br_valid),
    .br_tag    (br_tag),
    .br_data   (br_data),
    .br_ready  (br_ready),
    .ls_valid  (ls_valid),
    .ls_tag    (ls_tag),
    .ls_data   (ls_data),
    .ls_ready  (ls_ready),
    .cdb_valid (cdb_valid),
    .cdb_tag   (cdb_tag),
    .cdb_data  (cdb_data),
    .cdb_src   (cdb_src)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alu_valid = 0; br_valid = 0; ls_valid = 0;
    alu_tag = 0; br_tag = 0; ls_tag = 0;
    alu_data = 0; br_data = 0; ls_data = 0;
  endtask

  task automatic chk_idle(input string tag);
    chk_eq({tag, "_valid"}, 32'(cdb_valid), 32'd0);
    chk_eq({tag, "_tag"}, 32'(cdb_tag), 32'(TFREE));
    chk_eq({tag, "_data"}, cdb_data, 32'd0);
  endtask

  task automatic chk_bus(input string tag, input logic [4:0] t, input logic [31:0] d,
                         input logic [1:0] s);
    chk_eq({tag, "_valid"}, 32'(cdb_valid), 32'd1);
    chk_eq({tag, "_tag"}, 32'(cdb_tag), 32'(t));
    chk_eq({tag, "_data"}, cdb_data, d);
    chk_eq({tag, "_src"}, 32'(cdb_src), 32'(s));
  endtask

  initial begin
    logic [2:0] rdy;
    logic       v;
    int         seq [3];

    rst = 0; flush = 0;
    idle_inputs();
    alu_valid = 1; br_valid = 1; ls_valid = 1;
    alu_tag = 1; br_tag = 2; ls_tag = 3;

    // Reset held with every requester offering.
    for (int i = 0; i < 3; i++) begin
      step();
      chk_eq($sformatf("rst%0d_ready", i), 32'({alu_ready, br_ready, ls_ready}), 32'd0);
      chk_idle($sformatf("rst%0d", i));
      chk_eq($sformatf("rst%0d_src", i), 32'(cdb_src), 32'd0);
    end
    idle_inputs();
    rst = 1;
    step();
    chk_eq("rel_ready", 32'({alu_ready, br_ready, ls_ready}), 32'h7);

    // Single ALU push: visible only in the cycle after the following edge.
    alu_valid = 1; alu_tag = 3; alu_data = 32'h1234;
    step();
    idle_inputs();
    chk_idle("single_k");
    step();
    chk_bus("single_k1", 5'd3, 32'h1234, 2'd0);
    step();
    chk_idle("single_k2");

    // Restore last_grant to LS so ALU leads the rotation.
    rst = 0;
    step();
    rst = 1;
    step();

    seq = '{1, 1, 1};
    for (int i = 0; i < 13; i++) begin
      v = (i < 7);
      alu_valid = v; br_valid = v; ls_valid = v;
      alu_tag = 1; br_tag = 2; ls_tag = 3;
      alu_data = 32'h0A00 + 32'(seq[0]);
      br_data  = 32'h0B00 + 32'(seq[1]);
      ls_data  = 32'h0C00 + 32'(seq[2]);
      rdy = {alu_ready, br_ready, ls_ready};
      step();
      if (v && rdy[2]) seq[0]++;
      if (v && rdy[1]) seq[1]++;
      if (v && rdy[0]) seq[2]++;
      chk_eq($sformatf("rr%0d_valid", i), 32'(cdb_valid), 32'(RR_VALID[i]));
      chk_eq($sformatf("rr%0d_tag", i), 32'(cdb_tag), 32'(RR_TAG[i]));
      chk_eq($sformatf("rr%0d_data", i), cdb_data, RR_DATA[i]);
      if (RR_VALID[i]) chk_eq($sformatf("rr%0d_src", i), 32'(cdb_src), 32'(RR_SRC[i]));
      chk_eq($sformatf("rr%0d_ready", i), 32'({alu_ready, br_ready, ls_ready}),
             32'(RR_RDY[i]));
    end
    idle_inputs();

    // Flush with two ALU and one LS item waiting.
    alu_valid = 1; alu_tag = 4; alu_data = 32'h41;
    ls_valid = 1;  ls_tag = 5;  ls_data = 32'h51;
    step();
    chk_idle("fl_push1");
    alu_data = 32'h42; ls_data = 32'h52;
    step();
    chk_bus("fl_push2", 5'd5, 32'h51, 2'd2);
    chk_eq("fl_alu_full", 32'(alu_ready), 32'd0);
    idle_inputs();
    br_valid = 1; br_tag = 9; br_data = 32'h99;
    flush = 1;
    step();
    flush = 0;
    idle_inputs();
    chk_idle("fl_k1");
    chk_eq("fl_ready", 32'({alu_ready, br_ready, ls_ready}), 32'h7);
    for (int i = 0; i < 3; i++) begin
      step();
      chk_idle($sformatf("fl_drain%0d", i));
    end

    // last_grant survived the flush (LS), so ALU wins over branch.
    alu_valid = 1; alu_tag = 10; alu_data = 32'hAA;
    br_valid = 1;  br_tag = 11;  br_data = 32'hBB;
    step();
    idle_inputs();
    chk_idle("lg_k");
    step();
    chk_bus("lg_first", 5'd10, 32'hAA, 2'd0);
    step();
    chk_bus("lg_second", 5'd11, 32'hBB, 2'd1);
    step();
    chk_idle("lg_done");

    // Free-tag branch result is swallowed; the next one is broadcast.
    br_valid = 1; br_tag = TFREE; br_data = 32'hDEAD;
    step();
    br_tag = 7; br_data = 32'h77;
    chk_idle("free_k1");
    chk_eq("free_ready", 32'(br_ready), 32'd1);
    step();
    idle_inputs();
    chk_idle("free_k2");
    step();
    chk_bus("free_tag7", 5'd7, 32'h77, 2'd1);
    step();
    chk_idle("free_done");

    // Asynchronous reset between edges while queues are loaded.
    alu_valid = 1; br_valid = 1; ls_valid = 1;
    alu_tag = 1; br_tag = 2; ls_tag = 3;
    for (int i = 0; i < 3; i++) step();
    chk_eq("ar_busy", 32'(cdb_valid), 32'd1);
    #3;
    rst = 0;
    #1;
    chk_idle("ar_async");
    chk_eq("ar_src", 32'(cdb_src), 32'd0);
    chk_eq("ar_ready", 32'({alu_ready, br_ready, ls_ready}), 32'd0);
    idle_inputs();
    step();
    rst = 1;
    step();
    chk_eq("ar_rel_ready", 32'({alu_ready, br_ready, ls_ready}), 32'h7);
    chk_idle("ar_rel0");
    step();
    chk_idle("ar_rel1");
    step();
    chk_idle("ar_rel2");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/cdb_arbiter.md
CDB_ARBITER -- requirements
Module: cdb_arbiter

Interface
REQ-001 SHALL have parameter TAG_W, default `tagWidth (5), meaning ROB tag width including the tagFree encoding.
REQ-002 SHALL have parameter DATA_W, default `dataWidth (32), meaning result data width.
REQ-003 SHALL have parameter QDEPTH, default 2, meaning per-requester queue entries (power of two, >=2).
REQ-004 clk  input  1  sole clock, all state updates on posedge.
REQ-005 rst  input  1  reset, asynchronous assert, active-low (0 = reset).
REQ-006 flush  input  1  synchronous clear of all queued and in-flight results (mispredict).
REQ-007 alu_valid / br_valid / ls_valid  input  1 each  requester r offers a result.
REQ-008 alu_tag / br_tag / ls_tag  input  TAG_W each  destination ROB tag.
REQ-009 alu_data / br_data / ls_data  input  DATA_W each  result value.
REQ-010 alu_ready / br_ready / ls_ready  output  1 each  requester r's queue is not full.
REQ-011 cdb_valid  output  1  broadcast valid this cycle (drives ALU_ROB_valid-style consumers).
REQ-012 cdb_tag  output  TAG_W  broadcast tag.
REQ-013 cdb_data  output  DATA_W  broadcast data.
REQ-014 cdb_src  output  2  source of broadcast: 0 = ALU, 1 = branch, 2 = LSBuf, 3 = unused.

Function
REQ-015 Transfer SHALL occur at a posedge where r_valid && r_ready; the item SHALL be appended to queue r in order.
REQ-016 r_ready SHALL be a registered function of queue r occupancy only (ready = count < QDEPTH), with no combinational path from any input.
REQ-017 A full queue SHALL deassert ready even when a pop occurs in the same cycle; no same-cycle pass-through on full.
REQ-018 Each cycle, the arbiter SHALL grant exactly one non-empty queue head, round-robin starting at (last_grant + 1) mod 3, or none if all queues are empty.
REQ-019 The granted head SHALL be popped at the posedge and loaded into the cdb_* output registers; cdb_valid SHALL be 1 for exactly that one following cycle.
REQ-020 Minimum latency: an item accepted at posedge k SHALL appear on cdb_* during the cycle after posedge k+1.
REQ-021 last_grant SHALL update only on a grant; with all three queues continuously non-empty, grants SHALL cycle 0,1,2,0,... (no starvation, at most 2 cycles of wait per head).
REQ-022 Items with tag == `tagFree SHALL be accepted and discarded at the queue input, never broadcast.
REQ-023 When cdb_valid = 0, cdb_tag SHALL equal `tagFree and cdb_data SHALL equal 0.
REQ-024 flush = 1 at posedge k SHALL empty all queues, drop any push at k, force cdb_valid = 0 for the cycle after k, and assert all ready signals after k; last_grant SHALL be unchanged.
REQ-025 Queue pointers SHALL wrap modulo QDEPTH; a simultaneous push and pop on a non-full, non-empty queue SHALL keep count unchanged.

Reset
REQ-026 While rst = 0: all queues empty, cdb_valid = 0, cdb_tag = `tagFree, cdb_data = 0, cdb_src = 0, last_grant = 2 (ALU has first priority), all ready = 0.
REQ-027 Ready SHALL rise at the first posedge after rst deasserts; reset assertion mid-operation SHALL discard all pending items immediately, without waiting for a clock edge.

Structure
REQ-028 `tagWidth, `dataWidth, `tagFree and new `cdbSrcALU/`cdbSrcBranch/`cdbSrcLS encodings SHALL live in shared defines.v.
REQ-029 The per-requester FIFO SHALL be a sub-module cdb_queue (parameters TAG_W, DATA_W, QDEPTH; push/pop/full/empty/count), instantiated three times; the arbiter and output register SHALL stay in cdb_arbiter.

Verification
REQ-030 Reset: hold rst = 0 for 3 cycles with all valid = 1 -> no ready, cdb_valid = 0, cdb_tag = `tagFree throughout.
REQ-031 Single ALU push: tag = 3, data = 0x1234 accepted at edge k -> cdb_valid = 1, tag 3, data 0x1234, src 0 in the cycle after edge k+1 only.
REQ-032 All three push every cycle (tags 1/2/3) -> cdb_src sequence 0,1,2,0,1,2; each ready drops after 2 unserved items; no item is lost or reordered per source.
REQ-033 Flush with 2 ALU + 1 LS items queued -> cdb_valid = 0 in the next cycle, all ready = 1, and none of those items is ever broadcast.
REQ-034 Branch push with tag = `tagFree -> accepted, never appears on the CDB; the following branch push (tag 7) is broadcast normally.
REQ-035 Async reset asserted between edges while queues are full -> outputs reach reset values before the next posedge.
